alu_unit: RTL and testbench

- Parametrised successor of the single-cycle combinational ALU in the Execute stage.
- Accepts issued ops from the reservation station through a valid/ready handshake and computes integer ALU and branch results in one cycle.
- Buffers results in an in-order FIFO until the common data bus (CDB) grants broadcast.
- Resolves branches with separate taken and target outputs, and supports a pipeline flush.

---
 rtl/alu_unit_pkg.sv | 37 +++
 rtl/alu_unit_if.sv | 38 +++
 rtl/alu_unit_core.sv | 67 ++++++
 rtl/alu_unit.sv | 98 +++++++++
 tb/tb_alu_unit.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_unit_pkg.sv
// Shared opcode map and defaults for the execute-stage ALU unit.
// Opcode 0 is idle; anything not listed here computes to all-zero fields.
package alu_unit_pkg;

  localparam int XLEN_DEF = 32;
  localparam int OP_W_DEF = 7;

  typedef enum logic [OP_W_DEF-1:0] {
    OP_IDLE  = 7'd0,
    OP_ADD   = 7'd1,
    OP_SUB   = 7'd2,
    OP_AND   = 7'd3,
    OP_OR    = 7'd4,
    OP_XOR   = 7'd5,
    OP_ADDI  = 7'd6,
    OP_ANDI  = 7'd7,
    OP_ORI   = 7'd8,
    OP_XORI  = 7'd9,
    OP_SLL   = 7'd10,
    OP_SRL   = 7'd11,
    OP_SRA   = 7'd12,
    OP_SLLI  = 7'd13,
    OP_SRLI  = 7'd14,
    OP_SRAI  = 7'd15,
    OP_SLT   = 7'd16,
    OP_SLTU  = 7'd17,
    OP_SLTI  = 7'd18,
    OP_SLTIU = 7'd19,
    OP_BEQ   = 7'd20,
    OP_BNE   = 7'd21,
    OP_BLT   = 7'd22,
    OP_BGE   = 7'd23,
    OP_BLTU  = 7'd24,
    OP_BGEU  = 7'd25
  } alu_op_e;

endpackage

// File: rtl/alu_unit_if.sv
// Issue and CDB side of the ALU unit; slave is the unit, master is the driver.
interface alu_unit_if #(
  parameter int XLEN  = 32,
  parameter int OP_W  = 7,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic [XLEN-1:0]  in_vi;
  logic [XLEN-1:0]  in_vj;
  logic [XLEN-1:0]  in_imm;
  logic [XLEN-1:0]  in_pc;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             cdb_grant;
  logic [TAG_W-1:0] out_tag;
  logic [XLEN-1:0]  out_res;
  logic             out_is_br;
  logic             out_taken;
  logic [XLEN-1:0]  out_target;
  logic [CNT_W-1:0] occupancy;

  modport slave (
    input  in_valid, in_op, in_vi, in_vj, in_imm, in_pc, in_tag, cdb_grant,
    output in_ready, out_valid, out_tag, out_res, out_is_br, out_taken,
           out_target, occupancy
  );

  modport master (
    output in_valid, in_op, in_vi, in_vj, in_imm, in_pc, in_tag, cdb_grant,
    input  in_ready, out_valid, out_tag, out_res, out_is_br, out_taken,
           out_target, occupancy
  );
endinterface

// File: rtl/alu_unit_core.sv
// Combinational ALU/branch datapath: (op, vi, vj, imm, pc) -> (res, is_br, taken, target).
module alu_core
  import alu_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int OP_W = OP_W_DEF
) (
  input  logic [OP_W-1:0] op_i,
  input  logic [XLEN-1:0] vi_i,
  input  logic [XLEN-1:0] vj_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] res_o,
  output logic            is_br_o,
  output logic            taken_o,
  output logic [XLEN-1:0] target_o
);
  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] sh_v, sh_i;
  logic            eq, lt_s, lt_u, lti_s, lti_u;

  assign sh_v  = vj_i[SH_W-1:0];
  assign sh_i  = imm_i[SH_W-1:0];
  assign eq    = (vi_i == vj_i);
  assign lt_s  = ($signed(vi_i) < $signed(vj_i));
  assign lt_u  = (vi_i < vj_i);
  assign lti_s = ($signed(vi_i) < $signed(imm_i));
  assign lti_u = (vi_i < imm_i);

  always_comb begin
    res_o    = '0;
    is_br_o  = 1'b0;
    taken_o  = 1'b0;
    target_o = '0;
    case (op_i)
      OP_ADD:   res_o = vi_i + vj_i;
      OP_SUB:   res_o = vi_i - vj_i;
      OP_AND:   res_o = vi_i & vj_i;
      OP_OR:    res_o = vi_i | vj_i;
      OP_XOR:   res_o = vi_i ^ vj_i;
      OP_ADDI:  res_o = vi_i + imm_i;
      OP_ANDI:  res_o = vi_i & imm_i;
      OP_ORI:   res_o = vi_i | imm_i;
      OP_XORI:  res_o = vi_i ^ imm_i;
      OP_SLL:   res_o = vi_i << sh_v;
      OP_SRL:   res_o = vi_i >> sh_v;
      OP_SRA:   res_o = $signed(vi_i) >>> sh_v;
      OP_SLLI:  res_o = vi_i << sh_i;
      OP_SRLI:  res_o = vi_i >> sh_i;
      OP_SRAI:  res_o = $signed(vi_i) >>> sh_i;
      OP_SLT:   res_o = XLEN'(lt_s);
      OP_SLTU:  res_o = XLEN'(lt_u);
      OP_SLTI:  res_o = XLEN'(lti_s);
      OP_SLTIU: res_o = XLEN'(lti_u);
      OP_BEQ:   begin is_br_o = 1'b1; taken_o = eq;    end
      OP_BNE:   begin is_br_o = 1'b1; taken_o = !eq;   end
      OP_BLT:   begin is_br_o = 1'b1; taken_o = lt_s;  end
      OP_BGE:   begin is_br_o = 1'b1; taken_o = !lt_s; end
      OP_BLTU:  begin is_br_o = 1'b1; taken_o = lt_u;  end
      OP_BGEU:  begin is_br_o = 1'b1; taken_o = !lt_u; end
      default:  ;
    endcase
    // Non-branch ops leave target at zero.
    if (is_br_o) target_o = taken_o ? (pc_i + imm_i) : (pc_i + XLEN'(4));
  end
endmodule

// File: rtl/alu_unit.sv
// Issue-side ALU with an in-order result FIFO draining onto the CDB.
// rdy_in freezes all state; flush drops buffered and incoming ops.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int OP_W  = OP_W_DEF,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  input  logic       flush_in,
  alu_unit_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  res_q    [DEPTH];
  logic [XLEN-1:0]  target_q [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic             is_br_q  [DEPTH];
  logic             taken_q  [DEPTH];

  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop, not_empty, in_ready;

  logic [XLEN-1:0]  c_res, c_target;
  logic             c_is_br, c_taken;

  alu_core #(.XLEN(XLEN), .OP_W(OP_W)) u_core (
    .op_i    (bus.in_op),
    .vi_i    (bus.in_vi),
    .vj_i    (bus.in_vj),
    .imm_i   (bus.in_imm),
    .pc_i    (bus.in_pc),
    .res_o   (c_res),
    .is_br_o (c_is_br),
    .taken_o (c_taken),
    .target_o(c_target)
  );

  assign not_empty = (cnt_q != '0);
  assign in_ready  = (cnt_q != CNT_W'(DEPTH));
  assign push      = bus.in_valid && in_ready && rdy_in && !flush_in;
  assign pop       = not_empty && bus.cdb_grant && rdy_in && !flush_in;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (rdy_in) begin
      if (flush_in) begin
        wr_d  = '0;
        rd_d  = '0;
        cnt_d = '0;
      end else begin
        if (push) wr_d = wr_q + PTR_W'(1);
        if (pop)  rd_d = rd_q + PTR_W'(1);
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload needs no reset: outputs are gated by occupancy below.
  always_ff @(posedge clk_in) begin
    if (rst_in && push) begin
      res_q[wr_q]    <= c_res;
      target_q[wr_q] <= c_target;
      tag_q[wr_q]    <= bus.in_tag;
      is_br_q[wr_q]  <= c_is_br;
      taken_q[wr_q]  <= c_taken;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.occupancy  = cnt_q;
  assign bus.out_valid  = not_empty;
  assign bus.out_tag    = not_empty ? tag_q[rd_q]    : '0;
  assign bus.out_res    = not_empty ? res_q[rd_q]    : '0;
  assign bus.out_is_br  = not_empty && is_br_q[rd_q];
  assign bus.out_taken  = not_empty && taken_q[rd_q];
  assign bus.out_target = not_empty ? target_q[rd_q] : '0;
endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: driver pushes model results on accept,
// an independent negedge monitor compares and retires them on CDB grant.
module tb_alu_unit;
  import alu_unit_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] res;
    logic        br;
    logic        tk;
    logic [31:0] tgt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, rdy, flush;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];

  alu_unit_if #(.XLEN(32), .OP_W(7), .TAG_W(4), .DEPTH(DEPTH)) bus ();

  alu_unit #(.XLEN(32), .OP_W(7), .TAG_W(4), .DEPTH(DEPTH)) dut (
    .clk_in  (clk),
    .rst_in  (rst_n),
    .rdy_in  (rdy),
    .flush_in(flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model straight from the ISA rules.
  function automatic exp_t model(input logic [6:0] op, input logic [31:0] a, b, imm, pc,
                                 input logic [3:0] tag);
    exp_t e;
    longint sa, sb, si;
    int nb, ni;
    e.tag = tag; e.res = 0; e.br = 0; e.tk = 0; e.tgt = 0;
    sa = longint'($signed(a)); sb = longint'($signed(b)); si = longint'($signed(imm));
    nb = int'(b % 32); ni = int'(imm % 32);
    case (op)
      OP_ADD:   e.res = a + b;
      OP_SUB:   e.res = a - b;
      OP_AND:   e.res = a & b;
      OP_OR:    e.res = a | b;
      OP_XOR:   e.res = a ^ b;
      OP_ADDI:  e.res = a + imm;
      OP_ANDI:  e.res = a & imm;
      OP_ORI:   e.res = a | imm;
      OP_XORI:  e.res = a ^ imm;
      OP_SLL:   e.res = a << nb;
      OP_SRL:   e.res = a >> nb;
      OP_SRA:   e.res = a[31] ? ~((~a) >> nb) : (a >> nb);
      OP_SLLI:  e.res = a << ni;
      OP_SRLI:  e.res = a >> ni;
      OP_SRAI:  e.res = a[31] ? ~((~a) >> ni) : (a >> ni);
      OP_SLT:   e.res = (sa < sb) ? 1 : 0;
      OP_SLTU:  e.res = (a < b) ? 1 : 0;
      OP_SLTI:  e.res = (sa < si) ? 1 : 0;
      OP_SLTIU: e.res = (a < imm) ? 1 : 0;
      OP_BEQ:   begin e.br = 1; e.tk = (a == b); end
      OP_BNE:   begin e.br = 1; e.tk = (a != b); end
      OP_BLT:   begin e.br = 1; e.tk = (sa < sb); end
      OP_BGE:   begin e.br = 1; e.tk = (sa >= sb); end
      OP_BLTU:  begin e.br = 1; e.tk = (a < b); end
      OP_BGEU:  begin e.br = 1; e.tk = (a >= b); end
      default:  ;
    endcase
    if (e.br) e.tgt = e.tk ? pc + imm : pc + 32'd4;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // One clock: sample the handshake at negedge, update the model at posedge.
  task automatic step(output bit acc);
    bit rs, fl;
    exp_t e;
    @(negedge clk);
    rs  = rst_n;
    acc = rs && rdy && !flush && bus.in_valid && bus.in_ready;
    fl  = rs && rdy && flush;
    e   = model(bus.in_op, bus.in_vi, bus.in_vj, bus.in_imm, bus.in_pc, bus.in_tag);
    @(posedge clk);
    if (!rs || fl) exp_q.delete();
    else if (acc) exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(a);
  endtask

  task automatic issue(input logic [6:0] op, input logic [31:0] a, b, imm, pc,
                       input logic [3:0] tag);
    bit a_ok;
    int guard;
    bus.in_op = op; bus.in_vi = a; bus.in_vj = b; bus.in_imm = imm;
    bus.in_pc = pc; bus.in_tag = tag; bus.in_valid = 1'b1;
    a_ok = 0; guard = 0;
    while (!a_ok && guard < 20) begin step(a_ok); guard++; end
    if (!a_ok) begin
      errors++; checks++;
      $display("FAIL issue_timeout tag=%0d", tag);
    end
    bus.in_valid = 1'b0;
  endtask

  // Directed op with grant held: the op sits at the head right after acceptance.
  task automatic dir(input string name, input logic [6:0] op, input logic [31:0] a, b, imm, pc,
                     input logic [31:0] res, input bit br, tk, input logic [31:0] tgt);
    issue(op, a, b, imm, pc, 4'd5);
    chk({name, "_valid"}, 32'(bus.out_valid), 1);
    chk({name, "_res"}, bus.out_res, res);
    chk({name, "_br"}, 32'(bus.out_is_br), 32'(br));
    chk({name, "_tk"}, 32'(bus.out_taken), 32'(tk));
    chk({name, "_tgt"}, bus.out_target, tgt);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (bus.occupancy != 3'(exp_q.size()) || bus.in_ready != (exp_q.size() != DEPTH) ||
          bus.out_valid != (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL status occ=%0d rdy=%0b vld=%0b want_occ=%0d",
                 bus.occupancy, bus.in_ready, bus.out_valid, exp_q.size());
      end
      if (bus.out_valid && exp_q.size() > 0) begin
        checks++;
        if (bus.out_tag !== exp_q[0].tag || bus.out_res !== exp_q[0].res ||
            bus.out_is_br !== exp_q[0].br || bus.out_taken !== exp_q[0].tk ||
            bus.out_target !== exp_q[0].tgt) begin
          errors++;
          $display("FAIL head tag=%0d res=%0h br=%0b tk=%0b tgt=%0h want tag=%0d res=%0h br=%0b tk=%0b tgt=%0h",
                   bus.out_tag, bus.out_res, bus.out_is_br, bus.out_taken, bus.out_target,
                   exp_q[0].tag, exp_q[0].res, exp_q[0].br, exp_q[0].tk, exp_q[0].tgt);
        end
        if (rst_n && rdy && !flush && bus.cdb_grant) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit a;
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.cdb_grant = 1'b0; bus.in_op = '0; bus.in_vi = '0;
    bus.in_vj = '0; bus.in_imm = '0; bus.in_pc = '0; bus.in_tag = '0;
    idle(2);
    mon_en = 1'b1;
    chk("rst_occ", 32'(bus.occupancy), 0);
    chk("rst_ready", 32'(bus.in_ready), 1);
    chk("rst_valid", 32'(bus.out_valid), 0);
    rst_n = 1'b1;
    idle(1);

    // Directed ops, grant held high.
    bus.cdb_grant = 1'b1;
    issue(OP_ADD, 5, 7, 0, 0, 4'd3);
    chk("add_valid", 32'(bus.out_valid), 1);
    chk("add_res", bus.out_res, 12);
    chk("add_tag", 32'(bus.out_tag), 3);
    idle(1);
    chk("add_drained", 32'(bus.out_valid), 0);
    dir("sra",  OP_SRA,  32'h80000000, 4, 0, 0, 32'hF8000000, 0, 0, 0);
    dir("srl",  OP_SRL,  32'h80000000, 4, 0, 0, 32'h08000000, 0, 0, 0);
    dir("sll",  OP_SLL,  1, 33, 0, 0, 2, 0, 0, 0);
    dir("slt",  OP_SLT,  32'hFFFFFFFF, 1, 0, 0, 1, 0, 0, 0);
    dir("sltu", OP_SLTU, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0);
    dir("slti", OP_SLTI, 32'hFFFFFFFD, 0, 32'hFFFFFFFE, 0, 1, 0, 0, 0);
    dir("bge",  OP_BGE,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF8, 32'h100, 0, 1, 1, 32'hF8);
    dir("bltu", OP_BLTU, 2, 1, 8, 32'h100, 0, 1, 0, 32'h104);
    dir("unk",  7'd100,  3, 4, 5, 6, 0, 0, 0, 0);
    idle(2);

    // Backpressure: fill, hold a fifth, then drain in order.
    bus.cdb_grant = 1'b0;
    for (int i = 0; i < DEPTH; i++) issue(OP_ADDI, 32'(i), 0, 100, 0, 4'(8 + i));
    chk("full_ready", 32'(bus.in_ready), 0);
    bus.in_op = OP_ADDI; bus.in_vi = 9; bus.in_imm = 1; bus.in_tag = 4'd12; bus.in_valid = 1'b1;
    step(a); chk("held_1", 32'(a), 0);
    step(a); chk("held_2", 32'(a), 0);
    bus.cdb_grant = 1'b1;
    step(a); chk("no_accept_on_pop", 32'(a), 0);
    chk("ready_after_pop", 32'(bus.in_ready), 1);
    chk("order_tag", 32'(bus.out_tag), 9);
    step(a); chk("fifth_accept", 32'(a), 1);
    bus.in_valid = 1'b0;
    idle(6);

    // Flush drops buffered entries and the concurrent issue.
    bus.cdb_grant = 1'b0;
    for (int i = 0; i < 3; i++) issue(OP_ADD, 32'(i), 1, 0, 0, 4'(i));
    chk("pre_flush_occ", 32'(bus.occupancy), 3);
    flush = 1'b1; bus.in_valid = 1'b1; bus.cdb_grant = 1'b1;
    step(a);
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_occ", 32'(bus.occupancy), 0);
    chk("flush_valid", 32'(bus.out_valid), 0);
    idle(2);

    // rdy_in low freezes everything even with grant.
    bus.cdb_grant = 1'b0;
    issue(OP_OR, 1, 2, 0, 0, 4'd1);
    issue(OP_OR, 3, 4, 0, 0, 4'd2);
    bus.cdb_grant = 1'b1; rdy = 1'b0;
    idle(2);
    chk("frz_tag", 32'(bus.out_tag), 1);
    chk("frz_res", bus.out_res, 3);
    chk("frz_occ", 32'(bus.occupancy), 2);
    rdy = 1'b1;
    idle(3);

    // Reset mid-stream.
    bus.cdb_grant = 1'b0;
    issue(OP_XOR, 32'hF0, 32'h0F, 0, 0, 4'd7);
    issue(OP_BNE, 1, 2, 16, 32'h40, 4'd8);
    rst_n = 1'b0;
    idle(1);
    chk("mrst_valid", 32'(bus.out_valid), 0);
    chk("mrst_tag", 32'(bus.out_tag), 0);
    chk("mrst_res", bus.out_res, 0);
    chk("mrst_br", 32'(bus.out_is_br), 0);
    chk("mrst_tk", 32'(bus.out_taken), 0);
    chk("mrst_tgt", bus.out_target, 0);
    chk("mrst_occ", 32'(bus.occupancy), 0);
    rst_n = 1'b1;
    idle(1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rdy           = ($urandom_range(0, 9) != 0);
      flush         = ($urandom_range(0, 39) == 0);
      bus.cdb_grant = ($urandom_range(0, 2) != 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_op     = 7'($urandom_range(0, 31));
      bus.in_vi     = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 8));
      bus.in_vj     = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 8));
      bus.in_imm    = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
      bus.in_pc     = {$urandom_range(0, 65535), 2'b00};
      bus.in_tag    = 4'($urandom);
      step(a);
    end
    rdy = 1'b1; flush = 1'b0; bus.in_valid = 1'b0; bus.cdb_grant = 1'b1;
    idle(DEPTH + 2);
    chk("final_occ", 32'(bus.occupancy), 0);
    chk("final_q", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
